// File: rtl/bus_fifo_pkg.sv
// bus_fifo_pkg: shared widths and constants for the bus FIFO bank.
package bus_fifo_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}};
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/bus_fifo_bank_fifo_fwft.sv
// fifo_fwft: first-word fall-through circular FIFO with occupancy count and sticky overflow.
module fifo_fwft
  import bus_fifo_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic [width-1:0]          din,
  input  logic                      rd,
  output logic [width-1:0]          dout,
  output logic                      not_empty,
  output logic [CNT_W(depth)-1:0]   cnt,
  output logic                      ovf
);
  localparam int AW = $clog2(depth);
  localparam int CW = CNT_W(depth);
  typedef struct packed {
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          ovf;
  } fifo_state_t;
  fifo_state_t s_q, s_d;
  logic [width-1:0] mem_q [depth];
  logic full, do_rd, do_wr;
  // A read on a full FIFO frees the slot the same-cycle write needs.
  always_comb begin
    full     = s_q.cnt == CW'(depth);
    do_rd    = rd && not_empty;
    do_wr    = wr && (!full || do_rd);
    s_d.rptr = s_q.rptr + AW'(do_rd);
    s_d.wptr = s_q.wptr + AW'(do_wr);
    s_d.cnt  = s_q.cnt + CW'(do_wr) - CW'(do_rd);
    s_d.ovf  = s_q.ovf || (wr && !do_wr);
  end
  always_ff @(posedge clk) begin
    if (!reset) s_q <= '0;
    else s_q <= s_d;
  end
  always_ff @(posedge clk) begin
    if (reset && do_wr) mem_q[s_q.wptr] <= din;
  end
  assign not_empty = s_q.cnt != '0;
  assign dout      = not_empty ? mem_q[s_q.rptr] : '0;
  assign cnt       = s_q.cnt;
  assign ovf       = s_q.ovf;
endmodule

// File: rtl/bus_fifo_bank.sv
// bus_fifo_bank: per-device TX/RX FWFT FIFO pairs between host drivers and the bus.
// Optional destination filtering on pushes when BUS_FIFO_ADDR_FILTER_EN is defined.
module bus_fifo_bank
  import bus_fifo_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [bits-1:0][drvrs-1:0]                       wr_en,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]          wr_data,
  input  logic [bits-1:0][drvrs-1:0]                       rd_en,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]          rd_data,
  output logic [bits-1:0][drvrs-1:0]                       rd_valid,
  output logic [bits-1:0][drvrs-1:0]                       pndng,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]          D_pop,
  input  logic [bits-1:0][drvrs-1:0]                       pop,
  input  logic [bits-1:0][drvrs-1:0]                       push,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]          D_push,
  output logic [bits-1:0][drvrs-1:0][CNT_W(depth)-1:0]     tx_cnt,
  output logic [bits-1:0][drvrs-1:0][CNT_W(depth)-1:0]     rx_cnt,
  output logic [bits-1:0][drvrs-1:0]                       tx_ovf,
  output logic [bits-1:0][drvrs-1:0]                       rx_ovf
`ifdef BUS_FIFO_ADDR_FILTER_EN
  ,
  output logic [bits-1:0][drvrs-1:0]                       misroute
`endif
);
  for (genvar b = 0; b < bits; b++) begin : g_bus
    for (genvar d = 0; d < drvrs; d++) begin : g_dev
      logic push_ok;
`ifdef BUS_FIFO_ADDR_FILTER_EN
      logic hit, mis_q;
      assign hit     = D_push[b][d][pckg_sz-1 -: ID_W] inside {ID_W'(d), broadcast};
      assign push_ok = push[b][d] && hit;
      always_ff @(posedge clk) begin
        if (!reset) mis_q <= 1'b0;
        else if (push[b][d] && !hit) mis_q <= 1'b1;
      end
      assign misroute[b][d] = mis_q;
`else
      assign push_ok = push[b][d];
`endif
      fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk, .reset, .wr(wr_en[b][d]), .din(wr_data[b][d]), .rd(pop[b][d]),
        .dout(D_pop[b][d]), .not_empty(pndng[b][d]), .cnt(tx_cnt[b][d]), .ovf(tx_ovf[b][d])
      );
      fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk, .reset, .wr(push_ok), .din(D_push[b][d]), .rd(rd_en[b][d]),
        .dout(rd_data[b][d]), .not_empty(rd_valid[b][d]), .cnt(rx_cnt[b][d]), .ovf(rx_ovf[b][d])
      );
    end
  end
endmodule

// File: tb/tb_bus_fifo_bank.sv
// tb_bus_fifo_bank: queue-model checking of bus_fifo_bank plus directed literal checks.
module tb_bus_fifo_bank;
  localparam int B = 1, N = 4, W = 16, DP = 8, CW = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [B-1:0][N-1:0] wr_en, rd_en, pop, push, rd_valid, pndng, tx_ovf, rx_ovf;
  logic [B-1:0][N-1:0][W-1:0] wr_data, D_push, rd_data, D_pop;
  logic [B-1:0][N-1:0][CW-1:0] tx_cnt, rx_cnt;
`ifdef BUS_FIFO_ADDR_FILTER_EN
  logic [B-1:0][N-1:0] misroute;
`endif
  int passed = 0, total = 0;
  logic chk_en = 1'b0;

  bus_fifo_bank #(.bits(B), .drvrs(N), .pckg_sz(W), .depth(DP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf)
`ifdef BUS_FIFO_ADDR_FILTER_EN
    , .misroute(misroute)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] txm [N][$];
  logic [W-1:0] rxm [N][$];
  logic tovf [N];
  logic rovf [N];
  logic mis [N];

  // Model: each FIFO is a queue; reads happen before writes so a full FIFO with a read accepts the write.
  always @(posedge clk) begin
    bit acc;
    for (int d = 0; d < N; d++) begin
      if (!reset) begin
        txm[d].delete(); rxm[d].delete();
        tovf[d] = 1'b0; rovf[d] = 1'b0; mis[d] = 1'b0;
      end else begin
        if (pop[0][d] && txm[d].size() > 0) void'(txm[d].pop_front());
        if (wr_en[0][d]) begin
          if (txm[d].size() < DP) txm[d].push_back(wr_data[0][d]);
          else tovf[d] = 1'b1;
        end
        acc = push[0][d];
`ifdef BUS_FIFO_ADDR_FILTER_EN
        acc = push[0][d] && (D_push[0][d][15:8] == 8'(d) || D_push[0][d][15:8] == 8'hFF);
        if (push[0][d] && !acc) mis[d] = 1'b1;
`endif
        if (rd_en[0][d] && rxm[d].size() > 0) void'(rxm[d].pop_front());
        if (acc) begin
          if (rxm[d].size() < DP) rxm[d].push_back(D_push[0][d]);
          else rovf[d] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dev%0d: got %0h, expected %0h", nm, d, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < N; d++) begin
        chk("pndng", d, 32'(pndng[0][d]), 32'(txm[d].size() != 0));
        chk("D_pop", d, 32'(D_pop[0][d]), txm[d].size() != 0 ? 32'(txm[d][0]) : 32'd0);
        chk("tx_cnt", d, 32'(tx_cnt[0][d]), 32'(txm[d].size()));
        chk("tx_ovf", d, 32'(tx_ovf[0][d]), 32'(tovf[d]));
        chk("rd_valid", d, 32'(rd_valid[0][d]), 32'(rxm[d].size() != 0));
        chk("rd_data", d, 32'(rd_data[0][d]), rxm[d].size() != 0 ? 32'(rxm[d][0]) : 32'd0);
        chk("rx_cnt", d, 32'(rx_cnt[0][d]), 32'(rxm[d].size()));
        chk("rx_ovf", d, 32'(rx_ovf[0][d]), 32'(rovf[d]));
`ifdef BUS_FIFO_ADDR_FILTER_EN
        chk("misroute", d, 32'(misroute[0][d]), 32'(mis[d]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; pop = '0; push = '0;
  endtask

  initial begin
    idle();
    wr_data = '0; D_push = '0;
    wr_en = '1;
    tick();
    chk_en = 1'b1;
    tick();
    for (int d = 0; d < N; d++) begin
      chk("rst_cnt", d, 32'(tx_cnt[0][d]), 32'd0);
      chk("rst_pndng", d, 32'(pndng[0][d]), 32'd0);
      chk("rst_ovf", d, 32'(tx_ovf[0][d]), 32'd0);
    end
    reset = 1'b1;
    idle();
    // FWFT ordering on device 2
    wr_en[0][2] = 1'b1; wr_data[0][2] = 16'h1234;
    tick();
    chk("fwft_head", 2, 32'(D_pop[0][2]), 32'h1234);
    chk("fwft_pndng", 2, 32'(pndng[0][2]), 32'd1);
    chk("mdl_head", 2, 32'(txm[2][0]), 32'h1234);
    wr_data[0][2] = 16'h5678;
    tick();
    wr_en[0][2] = 1'b0;
    chk("fwft_cnt", 2, 32'(tx_cnt[0][2]), 32'd2);
    pop[0][2] = 1'b1;
    tick();
    chk("fwft_second", 2, 32'(D_pop[0][2]), 32'h5678);
    tick();
    pop[0][2] = 1'b0;
    chk("fwft_empty", 2, 32'(pndng[0][2]), 32'd0);
    chk("fwft_cnt0", 2, 32'(tx_cnt[0][2]), 32'd0);
    // Overflow on device 0
    wr_en[0][0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data[0][0] = 16'hA000 + 16'(i);
      tick();
    end
    wr_en[0][0] = 1'b0;
    chk("ovf_cnt", 0, 32'(tx_cnt[0][0]), 32'd8);
    chk("ovf_flag", 0, 32'(tx_ovf[0][0]), 32'd1);
    chk("mdl_ovf", 0, 32'(tovf[0]), 32'd1);
    pop[0][0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 0, 32'(D_pop[0][0]), 32'hA000 + 32'(i));
      tick();
    end
    pop[0][0] = 1'b0;
    chk("ovf_empty", 0, 32'(pndng[0][0]), 32'd0);
    chk("ovf_sticky", 0, 32'(tx_ovf[0][0]), 32'd1);
    // Full FIFO write + pop on device 1
    wr_en[0][1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data[0][1] = 16'hB000 + 16'(i);
      tick();
    end
    pop[0][1] = 1'b1; wr_data[0][1] = 16'hB0FF;
    tick();
    wr_en[0][1] = 1'b0;
    chk("fullrw_cnt", 1, 32'(tx_cnt[0][1]), 32'd8);
    chk("fullrw_ovf", 1, 32'(tx_ovf[0][1]), 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk("fullrw_drain", 1, 32'(D_pop[0][1]), 32'hB000 + 32'(i));
      tick();
    end
    chk("fullrw_tail", 1, 32'(D_pop[0][1]), 32'hB0FF);
    tick();
    pop[0][1] = 1'b0;
    chk("fullrw_empty", 1, 32'(pndng[0][1]), 32'd0);
    // RX path and pointer wrap on device 3
    push[0][3] = 1'b1; D_push[0][3] = 16'hFF01;
    tick();
    push[0][3] = 1'b0;
    chk("rx_valid", 3, 32'(rd_valid[0][3]), 32'd1);
    chk("rx_data", 3, 32'(rd_data[0][3]), 32'hFF01);
    rd_en[0][3] = 1'b1;
    tick();
    rd_en[0][3] = 1'b0;
    chk("rx_drop", 3, 32'(rd_valid[0][3]), 32'd0);
    for (int i = 0; i < 20; i++) begin
      push[0][3] = 1'b1; D_push[0][3] = 16'hFF10 + 16'(i);
      tick();
      push[0][3] = 1'b0;
      chk("rx_wrap", 3, 32'(rd_data[0][3]), 32'hFF10 + 32'(i));
      rd_en[0][3] = 1'b1;
      tick();
      rd_en[0][3] = 1'b0;
    end
    chk("rx_wrap_cnt", 3, 32'(rx_cnt[0][3]), 32'd0);
    // RX overflow then simultaneous push/read on a full FIFO
    push[0][1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      D_push[0][1] = 16'hFF20 + 16'(i);
      tick();
    end
    chk("rx_ovf", 1, 32'(rx_ovf[0][1]), 32'd1);
    rd_en[0][1] = 1'b1; D_push[0][1] = 16'hFF3C;
    tick();
    idle();
    chk("rx_fullrw", 1, 32'(rx_cnt[0][1]), 32'd8);
    chk("rx_fullrw_head", 1, 32'(rd_data[0][1]), 32'hFF21);
    // Reads on empty FIFOs are ignored
    pop = '1; rd_en[0][3] = 1'b1; rd_en[0][2] = 1'b1;
    tick();
    idle();
    chk("underflow", 3, 32'(tx_cnt[0][3]), 32'd0);
    chk("underflow_rx", 3, 32'(rx_cnt[0][3]), 32'd0);
    // Reset mid-transfer discards everything
    wr_en[0][0] = 1'b1; wr_data[0][0] = 16'h0001;
    tick();
    reset = 1'b0; pop[0][0] = 1'b1; push[0][1] = 1'b1;
    tick();
    reset = 1'b1;
    idle();
    chk("mid_rst_cnt", 0, 32'(tx_cnt[0][0]), 32'd0);
    chk("mid_rst_ovf", 0, 32'(tx_ovf[0][0]), 32'd0);
    chk("mid_rst_rx", 1, 32'(rx_cnt[0][1]), 32'd0);
    chk("mid_rst_rxovf", 1, 32'(rx_ovf[0][1]), 32'd0);
`ifdef BUS_FIFO_ADDR_FILTER_EN
    push[0][2] = 1'b1; D_push[0][2] = 16'h0107;
    tick();
    push[0][2] = 1'b0;
    chk("filt_drop", 2, 32'(rd_valid[0][2]), 32'd0);
    chk("filt_mis", 2, 32'(misroute[0][2]), 32'd1);
    push[0][2] = 1'b1; D_push[0][2] = 16'hFF07;
    tick();
    push[0][2] = 1'b0;
    chk("filt_bcast", 2, 32'(rd_data[0][2]), 32'hFF07);
`endif
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
